// File: rtl/core_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | core_ctrl_pkg                                                              |
// | Shared encodings for the multicycle core controller and its decoder.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package core_ctrl_pkg;

    localparam logic [3:0] OP_LW    = 4'b0000;
    localparam logic [3:0] OP_SW    = 4'b0001;
    localparam logic [3:0] OP_JMP   = 4'b0010;
    localparam logic [3:0] OP_BZ    = 4'b0100;
    localparam logic [3:0] OP_RTYPE = 4'b1000;
    localparam logic [3:0] OP_ADDI  = 4'b1100;
    localparam logic [3:0] OP_SUBI  = 4'b1101;
    localparam logic [3:0] OP_ANDI  = 4'b1110;
    localparam logic [3:0] OP_ORI   = 4'b1111;

    typedef logic [3:0] state_t;
    localparam state_t ST_FETCH  = 4'd0;
    localparam state_t ST_DECODE = 4'd1;
    localparam state_t ST_ADDR   = 4'd2;
    localparam state_t ST_MEM_RD = 4'd3;
    localparam state_t ST_WB_MEM = 4'd4;
    localparam state_t ST_MEM_WR = 4'd5;
    localparam state_t ST_EXEC_R = 4'd6;
    localparam state_t ST_EXEC_I = 4'd7;
    localparam state_t ST_WB_ALU = 4'd8;
    localparam state_t ST_BRANCH = 4'd9;
    localparam state_t ST_JUMP   = 4'd10;
    localparam state_t ST_TRAP   = 4'd11;

    typedef logic [2:0] iclass_t;
    localparam iclass_t CL_NOP     = 3'd0;
    localparam iclass_t CL_LW      = 3'd1;
    localparam iclass_t CL_SW      = 3'd2;
    localparam iclass_t CL_JMP     = 3'd3;
    localparam iclass_t CL_BZ      = 3'd4;
    localparam iclass_t CL_RTYPE   = 3'd5;
    localparam iclass_t CL_IMM     = 3'd6;
    localparam iclass_t CL_ILLEGAL = 3'd7;

    localparam logic [2:0] ALU_MOV = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_NOT = 3'b101;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_SEXT = 2'b10;

    // Lowest set function bit selects the ALU operation; no bit set means mov.
    function automatic logic [2:0] rtype_alu_op(input logic [5:0] fn);
        logic [2:0] r;
        r = ALU_MOV;
        for (int i = 5; i >= 0; i--) begin
            if (fn[i]) r = 3'(i);
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mcc_instr_decode.sv
// +----------------------------------------------------------------------------+
// | mcc_instr_decode                                                           |
// | Combinational instruction classifier: class, ALU op, write-back, window.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module mcc_instr_decode
    import core_ctrl_pkg::*;
(
    input  logic [15:0] instr_i,
    output iclass_t     class_o,
    output logic [2:0]  alu_op_o,
    output logic        writes_reg_o,
    output logic        is_window_o
);

    logic [3:0] op;
    logic [7:0] fn;
    logic [3:0] unused_mid;

    assign op         = instr_i[15:12];
    assign fn         = instr_i[7:0];
    assign unused_mid = instr_i[11:8];

    always_comb begin
        class_o      = CL_ILLEGAL;
        alu_op_o     = ALU_ADD;
        writes_reg_o = 1'b0;
        is_window_o  = 1'b0;
        case (op)
            OP_LW: begin
                class_o      = (instr_i == 16'h0000) ? CL_NOP : CL_LW;
                writes_reg_o = (instr_i != 16'h0000);
            end
            OP_SW:  class_o = CL_SW;
            OP_JMP: class_o = CL_JMP;
            OP_BZ: begin
                class_o  = CL_BZ;
                alu_op_o = ALU_SUB;
            end
            OP_RTYPE: begin
                class_o      = CL_RTYPE;
                alu_op_o     = rtype_alu_op(fn[5:0]);
                writes_reg_o = (fn[7:6] == 2'b00);
                is_window_o  = fn[7];
            end
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: begin
                class_o      = CL_IMM;
                alu_op_o     = {1'b0, op[1:0]} + 3'd1;
                writes_reg_o = 1'b1;
            end
            default: class_o = CL_ILLEGAL;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_core_controller.sv
// +----------------------------------------------------------------------------+
// | multicycle_core_controller                                                 |
// | FETCH/DECODE/EXEC/MEM/WB sequencer with handshaked, time-limited memory.   |
// | Optional macro MCC_ILLEGAL_TRAP_EN: undefined opcodes trap (adds trap).    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module multicycle_core_controller
    import core_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instruction,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        mem_read,
    output logic        mem_write,
    output logic        i_or_d,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic [1:0]  pc_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_op,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        set_window,
    output logic [1:0]  in_window,
    output logic        mem_error
`ifdef MCC_ILLEGAL_TRAP_EN
    ,
    output logic        trap
`endif
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    state_t         state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic           mem_error_q, mem_error_d;

    iclass_t        dec_class;
    logic [2:0]     dec_alu_op;
    logic           dec_writes;
    logic           dec_window;
    logic           is_mem_state;
    logic           timeout_hit;
    logic           unused_alu_zero;

    // The zero flag is qualified by the datapath using pc_write_cond.
    assign unused_alu_zero = alu_zero;

    mcc_instr_decode u_decode (
        .instr_i      (instruction),
        .class_o      (dec_class),
        .alu_op_o     (dec_alu_op),
        .writes_reg_o (dec_writes),
        .is_window_o  (dec_window)
    );

    assign is_mem_state = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);
    // A ready in the final allowed cycle completes the access instead of timing out.
    assign timeout_hit  = (MEM_TIMEOUT != 0) && is_mem_state && !mem_ready &&
                          (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FETCH;
            wait_cnt_q  <= '0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = '0;
        mem_error_d = mem_error_q | timeout_hit;
        if (is_mem_state && !mem_ready && !timeout_hit) begin
            wait_cnt_d = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
        end
        case (state_q)
            ST_FETCH: begin
                if (mem_ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                case (dec_class)
                    CL_NOP:          state_d = ST_FETCH;
                    CL_LW, CL_SW:    state_d = ST_ADDR;
                    CL_JMP:          state_d = ST_JUMP;
                    CL_BZ:           state_d = ST_BRANCH;
                    CL_RTYPE:        state_d = ST_EXEC_R;
                    CL_IMM:          state_d = ST_EXEC_I;
`ifdef MCC_ILLEGAL_TRAP_EN
                    default:         state_d = ST_TRAP;
`else
                    default:         state_d = ST_FETCH;
`endif
                endcase
            end
            ST_ADDR:   state_d = (dec_class == CL_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD: begin
                if (mem_ready)        state_d = ST_WB_MEM;
                else if (timeout_hit) state_d = ST_FETCH;
            end
            ST_MEM_WR: begin
                if (mem_ready || timeout_hit) state_d = ST_FETCH;
            end
            ST_EXEC_R: state_d = (!dec_window && dec_writes) ? ST_WB_ALU : ST_FETCH;
            ST_EXEC_I: state_d = ST_WB_ALU;
            ST_WB_MEM, ST_WB_ALU, ST_BRANCH, ST_JUMP: state_d = ST_FETCH;
`ifdef MCC_ILLEGAL_TRAP_EN
            ST_TRAP:   state_d = ST_TRAP;
`endif
            default:   state_d = ST_FETCH;
        endcase
    end

    // Outputs are forced inactive while reset is asserted.
    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = PCSRC_ALU;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REGB;
        alu_op        = ALU_MOV;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        set_window    = 1'b0;
        in_window     = 2'b00;
        mem_error     = 1'b0;
`ifdef MCC_ILLEGAL_TRAP_EN
        trap          = 1'b0;
`endif
        if (!rst) begin
            in_window = instruction[1:0];
            mem_error = mem_error_q;
            case (state_q)
                ST_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_ONE;
                    alu_op    = ALU_ADD;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                ST_DECODE: begin
                    alu_src_b = SRCB_SEXT;
                    alu_op    = ALU_ADD;
                end
                ST_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_SEXT;
                    alu_op    = ALU_ADD;
                end
                ST_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                ST_WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                ST_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                ST_EXEC_R: begin
                    alu_src_a  = 1'b1;
                    alu_op     = dec_alu_op;
                    set_window = dec_window;
                end
                ST_EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_SEXT;
                    alu_op    = dec_alu_op;
                end
                ST_WB_ALU: reg_write = 1'b1;
                ST_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALU_SUB;
                    pc_write_cond = 1'b1;
                    pc_src        = PCSRC_ALUOUT;
                end
                ST_JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = PCSRC_JUMP;
                end
                ST_TRAP: begin
                    in_window = 2'b00;
                    mem_error = 1'b0;
`ifdef MCC_ILLEGAL_TRAP_EN
                    trap      = 1'b1;
`endif
                end
                default: begin
                    in_window = 2'b00;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_core_controller.sv
// +----------------------------------------------------------------------------+
// | tb_multicycle_core_controller                                              |
// | Instruction-level reference model compared against the controller.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_multicycle_core_controller;

    localparam int TMO = 4;

    typedef enum {P_FETCH, P_DECODE, P_ADDR, P_MEMRD, P_WBMEM, P_MEMWR,
                  P_EXECR, P_EXECI, P_WBALU, P_BRANCH, P_JUMP, P_TRAP} phase_e;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       reg_write;
        logic       mem_to_reg;
        logic       set_window;
        logic [1:0] in_window;
        logic       mem_error;
    } ctl_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instruction = 16'h0000;
    logic        alu_zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
    logic [1:0]  pc_src, alu_src_b, in_window;
    logic        alu_src_a, reg_write, mem_to_reg, set_window, mem_error;
    logic [2:0]  alu_op;
`ifdef MCC_ILLEGAL_TRAP_EN
    logic        trap;
`endif

    always #5 clk = ~clk;

    multicycle_core_controller #(.MEM_TIMEOUT(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .instruction   (instruction),
        .alu_zero      (alu_zero),
        .mem_ready     (mem_ready),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .i_or_d        (i_or_d),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_src        (pc_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .set_window    (set_window),
        .in_window     (in_window),
        .mem_error     (mem_error)
`ifdef MCC_ILLEGAL_TRAP_EN
        ,
        .trap          (trap)
`endif
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] cur_ir = 16'h0000;
    logic        err_m = 1'b0;
    int          fix_fetch = -1;
    int          fix_mem = -1;
    int          az_force = -1;
    int          cycles, c_rw, c_irw, c_mr, c_m2r, c_sw, c_pwc, c_trap, first_irw, first_rw;
    ctl_t        act, first_act;

    function automatic logic [2:0] first_set(input logic [5:0] fn);
        for (int k = 0; k < 6; k++) if (fn[k]) return 3'(k);
        return 3'd0;
    endfunction

    // Expected control word for one cycle of a given instruction step.
    function automatic ctl_t expect_out(input phase_e p, input logic [15:0] ir,
                                        input logic rdy, input logic err);
        ctl_t e;
        e = '0;
        e.in_window = ir[1:0];
        e.mem_error = err;
        case (p)
            P_FETCH:  begin e.mem_read = 1; e.alu_src_b = 2'b01; e.alu_op = 3'd1;
                            e.ir_write = rdy; e.pc_write = rdy; end
            P_DECODE: begin e.alu_src_b = 2'b10; e.alu_op = 3'd1; end
            P_ADDR:   begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = 3'd1; end
            P_MEMRD:  begin e.mem_read = 1; e.i_or_d = 1; end
            P_WBMEM:  begin e.reg_write = 1; e.mem_to_reg = 1; end
            P_MEMWR:  begin e.mem_write = 1; e.i_or_d = 1; end
            P_EXECR:  begin e.alu_src_a = 1; e.alu_op = first_set(ir[5:0]); e.set_window = ir[7]; end
            P_EXECI:  begin
                e.alu_src_a = 1; e.alu_src_b = 2'b10;
                case (ir[15:12])
                    4'hC: e.alu_op = 3'd1;
                    4'hD: e.alu_op = 3'd2;
                    4'hE: e.alu_op = 3'd3;
                    default: e.alu_op = 3'd4;
                endcase
            end
            P_WBALU:  e.reg_write = 1;
            P_BRANCH: begin e.alu_src_a = 1; e.alu_op = 3'd2; e.pc_write_cond = 1; e.pc_src = 2'b01; end
            P_JUMP:   begin e.pc_write = 1; e.pc_src = 2'b10; end
            default:  e = '0;
        endcase
        return e;
    endfunction

    function automatic int pick(input int fix);
        if (fix >= 0) return fix;
        if ($urandom_range(0, 15) == 0) return TMO + 2;
        return int'($urandom_range(0, 2));
    endfunction

    task automatic clr_counts();
        cycles = 0; c_rw = 0; c_irw = 0; c_mr = 0; c_m2r = 0; c_sw = 0;
        c_pwc = 0; c_trap = 0; first_irw = 0; first_rw = 0;
    endtask

    task automatic check_lit(input string nm, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", nm, got, want);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, then compare.
    task automatic step(input logic r, input logic [15:0] ins, input logic rdy,
                        input ctl_t exp, input logic exp_trap, input string nm);
        @(negedge clk);
        rst         = r;
        instruction = ins;
        mem_ready   = rdy;
        alu_zero    = (az_force < 0) ? 1'($urandom_range(0, 1)) : az_force[0];
        #1;
        act = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, set_window,
               in_window, mem_error};
        cycles++;
        if (cycles == 1) first_act = act;
        c_rw  += int'(reg_write);
        c_irw += int'(ir_write);
        c_mr  += int'(mem_read);
        c_m2r += int'(mem_to_reg);
        c_sw  += int'(set_window);
        c_pwc += int'(pc_write_cond);
        if (ir_write && first_irw == 0) first_irw = cycles;
        if (reg_write && first_rw == 0) first_rw = cycles;
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s ir=%h: got %h, required %h", nm, ins, act, exp);
        end
`ifdef MCC_ILLEGAL_TRAP_EN
        c_trap += int'(trap);
        n_cmp++;
        if (trap !== exp_trap) begin
            n_err++;
            $display("FAIL %s_trap: got %b, required %b", nm, trap, exp_trap);
        end
`else
        if (exp_trap) begin
            n_err++;
            $display("FAIL %s_trap: trap expected but not built", nm);
        end
`endif
    endtask

    task automatic do_reset(input int n);
        repeat (n) step(1'b1, cur_ir, 1'b0, ctl_t'('0), 1'b0, "reset");
        err_m = 1'b0;
    endtask

    task automatic run_instr(input logic [15:0] ins);
        phase_e ph[$];
        logic   rdy;
        logic   done;
        int     s, c, guard;
        s = pick(fix_fetch); c = 0; guard = 0; done = 1'b0;
        while (!done && guard < 200) begin
            rdy = (c == s);
            step(1'b0, cur_ir, rdy, expect_out(P_FETCH, cur_ir, rdy, err_m), 1'b0, "fetch");
            guard++;
            if (rdy) done = 1'b1;
            else if (c + 1 == TMO) begin err_m = 1'b1; s = pick(fix_fetch); c = 0; end
            else c++;
        end
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL fetch_bound: got no fetch within %0d cycles, required completion", guard);
            return;
        end
        cur_ir = ins;
        ph.push_back(P_DECODE);
        if (ins != 16'h0000) begin
            case (ins[15:12])
                4'h0: begin ph.push_back(P_ADDR); ph.push_back(P_MEMRD); ph.push_back(P_WBMEM); end
                4'h1: begin ph.push_back(P_ADDR); ph.push_back(P_MEMWR); end
                4'h2: ph.push_back(P_JUMP);
                4'h4: ph.push_back(P_BRANCH);
                4'h8: begin
                    ph.push_back(P_EXECR);
                    if (ins[7:6] == 2'b00) ph.push_back(P_WBALU);
                end
                4'hC, 4'hD, 4'hE, 4'hF: begin ph.push_back(P_EXECI); ph.push_back(P_WBALU); end
                default: begin
`ifdef MCC_ILLEGAL_TRAP_EN
                    ph.push_back(P_TRAP);
`endif
                end
            endcase
        end
        foreach (ph[i]) begin
            if (ph[i] == P_MEMRD || ph[i] == P_MEMWR) begin
                s = pick(fix_mem);
                for (int k = 0; k < 2 * TMO; k++) begin
                    rdy = (k == s);
                    step(1'b0, cur_ir, rdy, expect_out(ph[i], cur_ir, rdy, err_m), 1'b0, ph[i].name());
                    if (rdy) break;
                    if (k + 1 == TMO) begin err_m = 1'b1; return; end
                end
            end else if (ph[i] == P_TRAP) begin
                repeat (3) step(1'b0, cur_ir, 1'($urandom_range(0, 1)), ctl_t'('0), 1'b1, "trap");
                do_reset(1);
                return;
            end else begin
                rdy = 1'($urandom_range(0, 1));
                step(1'b0, cur_ir, rdy, expect_out(ph[i], cur_ir, rdy, err_m), 1'b0, ph[i].name());
            end
        end
    endtask

    function automatic logic [15:0] rand_instr();
        case ($urandom_range(0, 8))
            0: return {4'h0, 12'($urandom)};
            1: return {4'h1, 12'($urandom)};
            2: return {4'h2, 12'($urandom)};
            3: return {4'h4, 12'($urandom)};
            4, 5: return {4'h8, 12'($urandom)};
            6: return {2'b11, 14'($urandom)};
            7: return 16'h0000;
            default: return {8'h80, 2'b00, 6'($urandom)};
        endcase
    endfunction

    initial begin
        clr_counts();
        do_reset(2);

        fix_fetch = 0; fix_mem = 0;
        clr_counts(); run_instr(16'h8002);
        check_lit("add_cycles", cycles, 4);
        check_lit("add_ir_write_at", first_irw, 1);
        check_lit("add_reg_write_at", first_rw, 4);
        check_lit("add_reg_write_cnt", c_rw, 1);

        fix_mem = 3;
        clr_counts(); run_instr(16'h0105);
        check_lit("lw_cycles", cycles, 8);
        check_lit("lw_mem_read_cnt", c_mr, 5);
        check_lit("lw_reg_write_cnt", c_rw, 1);
        check_lit("lw_mem_to_reg_cnt", c_m2r, 1);
        fix_mem = 0;

        for (int z = 0; z < 2; z++) begin
            az_force = z;
            clr_counts(); run_instr(16'h4207);
            check_lit("bz_cycles", cycles, 3);
            check_lit("bz_pc_write_cond_cnt", c_pwc, 1);
        end
        az_force = -1;

        clr_counts(); run_instr(16'h8081);
        check_lit("win_cycles", cycles, 3);
        check_lit("win_set_window_cnt", c_sw, 1);
        check_lit("win_reg_write_cnt", c_rw, 0);
        clr_counts(); run_instr(16'h0000);
        check_lit("nop_cycles", cycles, 2);
        check_lit("nop_reg_write_cnt", c_rw, 0);
        clr_counts(); run_instr(16'h1203);
        check_lit("sw_cycles", cycles, 4);
        clr_counts(); run_instr(16'h2ABC);
        check_lit("jmp_cycles", cycles, 3);
        clr_counts(); run_instr(16'hE123);
        check_lit("andi_cycles", cycles, 4);
        clr_counts(); run_instr(16'h3000);
`ifdef MCC_ILLEGAL_TRAP_EN
        check_lit("illegal_trap_cycles", c_trap, 3);
`else
        check_lit("illegal_nop_cycles", cycles, 2);
`endif

        // Fetch stuck without ready: error after the fourth stall, then retry.
        do_reset(1);
        for (int k = 0; k < TMO; k++)
            step(1'b0, cur_ir, 1'b0, expect_out(P_FETCH, cur_ir, 1'b0, err_m), 1'b0, "tmo_stall");
        err_m = 1'b1;
        clr_counts(); run_instr(16'h0000);
        check_lit("tmo_mem_error", int'(first_act.mem_error), 1);
        check_lit("tmo_retry_mem_read", int'(first_act.mem_read), 1);

        fix_fetch = -1; fix_mem = -1;
        for (int n = 0; n < 300; n++) run_instr(rand_instr());

        // Reset in the middle of a stalled store.
        fix_fetch = 0;
        step(1'b0, cur_ir, 1'b1, expect_out(P_FETCH, cur_ir, 1'b1, err_m), 1'b0, "fetch");
        cur_ir = 16'h1203;
        step(1'b0, cur_ir, 1'b0, expect_out(P_DECODE, cur_ir, 1'b0, err_m), 1'b0, "decode");
        step(1'b0, cur_ir, 1'b0, expect_out(P_ADDR, cur_ir, 1'b0, err_m), 1'b0, "addr");
        repeat (2) step(1'b0, cur_ir, 1'b0, expect_out(P_MEMWR, cur_ir, 1'b0, err_m), 1'b0, "memwr_stall");
        do_reset(2);
        clr_counts(); run_instr(16'h8002);
        check_lit("rst_abort_mem_write", int'(first_act.mem_write), 0);
        check_lit("rst_abort_mem_error", int'(first_act.mem_error), 0);
        check_lit("rst_abort_fetch", int'(first_act.mem_read), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
